spi_2_arbiter: RTL and testbench
================================

Name: spi_2_arbiter

Overview:
- Shares one spi_2 SPI master between NREQ command requesters. Arbitration is round-robin.
- Latches the granted command and holds it stable on driver_data/driver_cfg for the whole transfer. Paces the master with master_en and detects completion from driver_read.
- Returns one response per command (read data or ack, with error flag).
- Sits between the system command sources and the SPI master. Burst commands are rejected.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DWIDTH, 32, SPI data width (matches spi_2_pkg)
- AWIDTH, 8, SPI address width (matches spi_2_pkg)
- CMD_W, DWIDTH+AWIDTH+5, command word width (equals master driver_data width)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester command valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_cmd  in  NREQ*CMD_W  commands; requester i at [i*CMD_W +: CMD_W]
- req_cfg  in  NREQ*2  SPI mode {cpol,cpha} per requester
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  $clog2(NREQ)  requester index of response
- rsp_data  out  DWIDTH  read data (0 for writes/errors)
- rsp_err  out  1  command rejected
- busy  out  1  state != IDLE
- master_en  out  1  master state-advance enable
- driver_data  out  CMD_W  command to master
- driver_cfg  out  2  mode to master
- driver_read  in  1  master in LOAD state
- spi_slv_read_data  in  DWIDTH  master RX register

Behaviour:
- Command fields:
  - ss = cmd[CMD_W-1:CMD_W-2]
  - t_type = cmd[CMD_W-3:CMD_W-4]
  - size = cmd[CMD_W-5:CMD_W-6]
  - t_type 00 = write, 01 = read, 1x = burst.
- Reset values: state BOOT, rr pointer 0, hold regs 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_err 0, driver_data 0, driver_cfg 0, busy 1.
- master_en is combinational:
  - BOOT: master_en = ~driver_read
  - ISSUE: master_en = 1
  - RUN: master_en = ~driver_read
  - all other states: 0
  - It is never registered, so the master cannot relaunch a stale command.
- BOOT:
  - Drives the master out of its reset state.
  - Moves to IDLE on the first cycle driver_read=1.
- IDLE:
  - Grants the first asserted req_valid at or after the rr pointer, searching upward with wrap.
  - req_ready[g] = 1 combinationally in the same cycle.
  - On that edge: latch cmd and cfg into the hold regs (driving driver_data/driver_cfg), latch id = g, and set rr pointer to (g+1) mod NREQ.
  - If t_type[1]=1 or size=2'b11, go to RESP with rsp_err=1 and rsp_data=0; the master is not touched.
  - Otherwise go to ISSUE.
  - No req_valid: stay in IDLE, all req_ready=0.
- ISSUE:
  - One cycle; master_en=1 while the master sits in LOAD, so it latches driver_data.
  - Go to RUN.
- RUN:
  - Wait while driver_read=0; master_en stays 1.
  - On the first cycle driver_read=1 (transfer complete), master_en=0 and the master parks in LOAD.
  - On that edge: rsp_data = spi_slv_read_data if t_type=01, else 0; rsp_err=0; go to RESP.
- RESP:
  - rsp_valid=1 and response fields held stable until rsp_ready.
  - On the rsp_valid & rsp_ready edge go to IDLE; new grants resume in the following cycle.
- Hold regs (driver_data/driver_cfg) change only in IDLE on a grant. They are stable through ISSUE/RUN/RESP, so ss_n is stable.
- Only one command is in flight at a time; a requester's command is accepted only after the prior response is consumed.
- Async reset at any point returns everything to reset values. The master shares rst_n, so both restart via BOOT.
- rr pointer wraps NREQ-1 → 0. A lone requester is granted back-to-back; no starvation is possible.

Test Plan:
- Reset, master model needs 1 cycle in RESET: master_en=1 until driver_read=1, then 0. Arbiter idles with busy=0 and all req_ready=0.
- Req1 write cmd (ss=2, t_type=00, size=00, data=0xA5), cfg=2'b01 → req_ready[1] one cycle; driver_data=cmd, driver_cfg=01 held. master_en high until driver_read returns. rsp_valid with id=1, data=0, err=0.
- Req0 read (size=10), slave model returns 0xDEADBEEF → rsp_data=0xDEADBEEF, rsp_id=0.
- Req0..3 all valid continuously → grant order 0,1,2,3,0. Each grant follows the prior rsp handshake.
- Req2 cmd t_type=10, then one with size=11 → immediate rsp_err=1. master_en stays 0 and driver_read never drops.
- rst_n low mid-RUN → outputs return to reset values; BOOT sequence repeats; a subsequent read completes correctly.
- rsp_ready held low 10 cycles in RESP → rsp fields stable, master_en=0, no req_ready asserted.

Source files
------------

// File: rtl/spi_2_arbiter.sv
// spi_2_arbiter: shares one spi_2 SPI master between NREQ command requesters.
//
// Requesters are served round-robin, one command at a time. The granted
// command and SPI mode are latched into hold registers that drive the master
// for the whole transfer. The master is paced with master_en, and completion
// is detected when driver_read (master in LOAD) returns. Each accepted command
// produces exactly one response. Burst commands and size=11 are rejected
// without touching the master.
//
// Handshakes (both sides use strict valid/ready semantics): a transfer happens
// on a rising clk edge where valid and ready are both high. A requester keeps
// req_valid and its req_cmd/req_cfg stable until it sees its req_ready bit.
// rsp_valid and the rsp_* fields stay stable until rsp_ready is high.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/ready    per-requester command handshake (ready is one-hot or 0)
//   req_cmd, req_cfg   packed commands and {cpol,cpha} modes, requester i at slice i
//   rsp_*              response channel (id, read data, error flag)
//   busy               high whenever the arbiter is not idle
//   master_en          combinational state-advance enable for the master
//   driver_data/cfg    held command and mode seen by the master
//   driver_read        master sits in its LOAD state
//   spi_slv_read_data  master receive register
//   state_dbg          current FSM state (BOOT=0 IDLE=1 ISSUE=2 RUN=3 RESP=4)

module spi_2_arbiter #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8,
  parameter int CMD_W  = DWIDTH + AWIDTH + 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*CMD_W-1:0]     req_cmd,
  input  logic [NREQ*2-1:0]         req_cfg,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [DWIDTH-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      master_en,
  output logic [CMD_W-1:0]          driver_data,
  output logic [1:0]                driver_cfg,
  input  logic                      driver_read,
  input  logic [DWIDTH-1:0]         spi_slv_read_data,
  output logic [2:0]                state_dbg
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_RUN   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_id;
  logic             grant_any;
  logic [CMD_W-1:0] grant_cmd;
  logic [1:0]       grant_cfg;
  logic             grant_bad;
  logic             held_is_read;

  // Round-robin search: first asserted req_valid at or after rr_ptr, with wrap.
  always_comb begin
    int unsigned idx;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx[IDW-1:0];
      end
    end
  end

  assign grant_cmd = req_cmd[grant_id*CMD_W +: CMD_W];
  assign grant_cfg = req_cfg[grant_id*2 +: 2];

  // Bursts (t_type=1x) and size=11 are rejected up front.
  assign grant_bad    = grant_cmd[CMD_W-3] | (grant_cmd[CMD_W-5:CMD_W-6] == 2'b11);
  assign held_is_read = (driver_data[CMD_W-3:CMD_W-4] == 2'b01);

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_any) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Kept combinational so the master can never act on a stale enable after
  // it has parked in LOAD.
  always_comb begin
    case (state)
      S_BOOT:  master_en = ~driver_read;
      S_ISSUE: master_en = 1'b1;
      S_RUN:   master_en = ~driver_read;
      default: master_en = 1'b0;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      rr_ptr      <= '0;
      driver_data <= '0;
      driver_cfg  <= '0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          if (driver_read) state <= S_IDLE;
        end
        S_IDLE: begin
          if (grant_any) begin
            driver_data <= grant_cmd;
            driver_cfg  <= grant_cfg;
            rsp_id      <= grant_id;
            rr_ptr      <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            if (grant_bad) begin
              rsp_err  <= 1'b1;
              rsp_data <= '0;
              state    <= S_RESP;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          state <= S_RUN;
        end
        S_RUN: begin
          if (driver_read) begin
            rsp_data <= held_is_read ? spi_slv_read_data : '0;
            rsp_err  <= 1'b0;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_2_arbiter.sv
// Testbench for spi_2_arbiter: random and directed requester traffic against a
// transaction-level model (round-robin order, one command in flight, expected
// response queue) plus a small behavioural spi_2 master model.

module tb_spi_2_arbiter;

  localparam int NREQ   = 4;
  localparam int DWIDTH = 32;
  localparam int AWIDTH = 8;
  localparam int CMD_W  = DWIDTH + AWIDTH + 5;
  localparam int IDW    = $clog2(NREQ);
  localparam int LOW_W  = CMD_W - 6;
  localparam int EW     = IDW + 1 + DWIDTH;

  localparam int PH_WAIT = 0;  // granted, master not yet launched
  localparam int PH_RUN  = 1;  // master transferring
  localparam int PH_DONE = 2;  // response pending

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*CMD_W-1:0] req_cmd;
  logic [NREQ*2-1:0]     req_cfg;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [DWIDTH-1:0]     rsp_data;
  logic                  rsp_err;
  logic                  busy;
  logic                  master_en;
  logic [CMD_W-1:0]      driver_data;
  logic [1:0]            driver_cfg;
  logic                  driver_read;
  logic [DWIDTH-1:0]     spi_slv_read_data;
  logic [2:0]            state_dbg;

  spi_2_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .CMD_W(CMD_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_cfg(req_cfg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .master_en(master_en),
    .driver_data(driver_data), .driver_cfg(driver_cfg), .driver_read(driver_read),
    .spi_slv_read_data(spi_slv_read_data), .state_dbg(state_dbg)
  );

  // ---------------- spi_2 master model ----------------
  // 0 = RESET, 1 = LOAD, 2 = BUSY. Advances only while master_en is high.
  logic [1:0]        mst;
  int                mst_cnt;
  logic [DWIDTH-1:0] slave_rx;
  logic              fixed_word_en = 1'b0;
  logic [DWIDTH-1:0] fixed_word = '0;

  assign driver_read       = (mst == 2'd1);
  assign spi_slv_read_data = slave_rx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst      <= 2'd0;
      mst_cnt  <= 0;
      slave_rx <= '0;
    end else if (master_en) begin
      case (mst)
        2'd0: mst <= 2'd1;
        2'd1: begin
          mst     <= 2'd2;
          mst_cnt <= $urandom_range(0, 4);
        end
        default: begin
          if (mst_cnt == 0) begin
            mst      <= 2'd1;
            slave_rx <= fixed_word_en ? fixed_word : DWIDTH'($urandom);
          end else begin
            mst_cnt <= mst_cnt - 1;
          end
        end
      endcase
    end
  end

  // ---------------- scoreboard / model state ----------------
  logic [EW-1:0]     exp_q[$];
  int                grant_log[$];
  int                n_checks = 0;
  int                n_pass = 0;

  bit                booted = 0;
  bit                outst = 0;
  int                phase = PH_WAIT;
  int                cur_id = 0;
  logic [CMD_W-1:0]  cur_cmd = '0;
  logic [1:0]        cur_cfg = '0;
  int                rr = 0;
  logic [DWIDTH-1:0] last_rsp_data = '0;

  logic              pend_v[NREQ];
  logic [CMD_W-1:0]  pend_c[NREQ];
  logic [1:0]        pend_f[NREQ];
  int                refill_pct = 0;
  int                rsp_ready_pct = 100;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [CMD_W-1:0] mk_cmd(input logic [1:0] ss, input logic [1:0] t,
                                               input logic [1:0] sz, input logic [LOW_W-1:0] low);
    return {ss, t, sz, low};
  endfunction

  function automatic logic [CMD_W-1:0] gen_cmd();
    logic [1:0] t;
    logic [1:0] sz;
    int r;
    r  = $urandom_range(0, 9);
    t  = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : 2'($urandom_range(2, 3));
    sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    return mk_cmd(2'($urandom_range(0, 3)), t, sz, LOW_W'({$urandom, $urandom}));
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    logic [NREQ-1:0] exp_ready;
    logic            exp_men;
    logic [EW-1:0]   e;
    bit              gv;
    int              g;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (!pend_v[i] && $urandom_range(0, 99) < refill_pct) begin
        pend_v[i] = 1'b1;
        pend_c[i] = gen_cmd();
        pend_f[i] = 2'($urandom_range(0, 3));
      end
      req_valid[i]               = pend_v[i];
      req_cmd[i*CMD_W +: CMD_W]  = pend_c[i];
      req_cfg[i*2 +: 2]          = pend_f[i];
    end
    rsp_ready = ($urandom_range(0, 99) < rsp_ready_pct);
    #1;

    // Expected grant: first pending requester at or after rr, wrapping.
    gv = 0;
    g  = 0;
    if (booted && !outst) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!gv && pend_v[(rr + k) % NREQ]) begin
          gv = 1;
          g  = (rr + k) % NREQ;
        end
      end
    end
    exp_ready = gv ? (NREQ'(1) << g) : '0;
    check("req_ready", req_ready, exp_ready);
    check("busy", busy, !(booted && !outst));

    if (!booted) exp_men = !driver_read;
    else if (outst && phase == PH_WAIT) exp_men = 1'b1;
    else if (outst && phase == PH_RUN) exp_men = !driver_read;
    else exp_men = 1'b0;
    check("master_en", master_en, exp_men);
    check("rsp_valid", rsp_valid, outst && phase == PH_DONE);

    if (outst) begin
      check("driver_data", driver_data, cur_cmd);
      check("driver_cfg", driver_cfg, cur_cfg);
    end
    if (outst && phase == PH_DONE) begin
      check("exp_q_size", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        check("rsp_id", rsp_id, e[EW-1 -: IDW]);
        check("rsp_err", rsp_err, e[DWIDTH]);
        check("rsp_data", rsp_data, e[DWIDTH-1:0]);
      end
    end

    // Advance the transaction model across the coming rising edge.
    if (!booted) begin
      if (driver_read) booted = 1;
    end else if (gv) begin
      outst     = 1;
      cur_id    = g;
      cur_cmd   = pend_c[g];
      cur_cfg   = pend_f[g];
      pend_v[g] = 1'b0;
      rr        = (g + 1) % NREQ;
      grant_log.push_back(g);
      if (cur_cmd[CMD_W-3] || cur_cmd[CMD_W-5 -: 2] == 2'b11) begin
        phase = PH_DONE;
        exp_q.push_back({IDW'(g), 1'b1, {DWIDTH{1'b0}}});
      end else begin
        phase = PH_WAIT;
      end
    end else if (outst) begin
      case (phase)
        PH_WAIT: phase = PH_RUN;
        PH_RUN: begin
          if (driver_read) begin
            phase = PH_DONE;
            exp_q.push_back({IDW'(cur_id), 1'b0,
                             (cur_cmd[CMD_W-3 -: 2] == 2'b01) ? spi_slv_read_data : {DWIDTH{1'b0}}});
          end
        end
        default: begin
          if (rsp_ready) begin
            last_rsp_data = rsp_data;
            e     = exp_q.pop_front();
            outst = 0;
          end
        end
      endcase
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_idle(input int budget);
    int pending;
    int left;
    left = budget;
    pending = 1;
    while (left > 0 && pending != 0) begin
      step();
      left--;
      pending = outst ? 1 : 0;
      for (int i = 0; i < NREQ; i++) if (pend_v[i]) pending++;
      if (!booted) pending++;
    end
    check("idle_timeout", pending, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_driver_data", driver_data, 0);
    check("rst_driver_cfg", driver_cfg, 0);
    check("rst_master_en", master_en, !driver_read);
    booted = 0;
    outst  = 0;
    rr     = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int left;
    req_valid = '0;
    req_cmd   = '0;
    req_cfg   = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 1'b0;
      pend_c[i] = '0;
      pend_f[i] = '0;
    end

    do_reset();
    wait_idle(20);

    // Requester 1 write, mode 01.
    pend_v[1] = 1'b1;
    pend_c[1] = mk_cmd(2'd2, 2'b00, 2'b00, LOW_W'(8'hA5));
    pend_f[1] = 2'b01;
    wait_idle(100);

    // Requester 0 read returning a fixed word.
    fixed_word_en = 1'b1;
    fixed_word    = 32'hDEADBEEF;
    pend_v[0] = 1'b1;
    pend_c[0] = mk_cmd(2'd1, 2'b01, 2'b10, LOW_W'(24'h123456));
    pend_f[0] = 2'b11;
    wait_idle(100);
    check("read_deadbeef", last_rsp_data, 32'hDEADBEEF);
    fixed_word_en = 1'b0;

    // Burst command rejected, response held with rsp_ready low for 10+ cycles.
    pend_v[2] = 1'b1;
    pend_c[2] = mk_cmd(2'd0, 2'b10, 2'b00, LOW_W'(16'hBEEF));
    pend_f[2] = 2'b00;
    rsp_ready_pct = 0;
    run(12);
    rsp_ready_pct = 100;
    wait_idle(50);

    // size=11 rejected too.
    pend_v[2] = 1'b1;
    pend_c[2] = mk_cmd(2'd3, 2'b00, 2'b11, LOW_W'(16'h0F0F));
    pend_f[2] = 2'b10;
    wait_idle(50);

    // Random traffic with back-pressure on the response channel.
    refill_pct    = 30;
    rsp_ready_pct = 70;
    run(1500);

    // Reset while a transfer is running.
    left = 300;
    while (left > 0 && !(outst && phase == PH_RUN)) begin
      step();
      left--;
    end
    check("reached_run", outst && phase == PH_RUN, 1);
    do_reset();

    // All requesters continuously valid with reads: order starts at 0 after reset.
    refill_pct    = 0;
    rsp_ready_pct = 100;
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 1'b1;
      pend_c[i] = mk_cmd(2'(i), 2'b01, 2'b10, LOW_W'($urandom));
      pend_f[i] = 2'(i);
    end
    grant_log.delete();
    refill_pct = 100;
    left = 400;
    while (left > 0 && grant_log.size() < 5) begin
      step();
      left--;
    end
    check("rr_grants_seen", grant_log.size() >= 5, 1);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
      check("rr_order", grant_log[i], i % NREQ);
    end

    // More random traffic, then drain.
    refill_pct    = 40;
    rsp_ready_pct = 60;
    run(800);
    refill_pct    = 0;
    rsp_ready_pct = 100;
    wait_idle(400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
